mig_traffic_checker: RTL
========================

// Module: mig_traffic_checker
// PURPOSE
//  Parametrised DDR3 traffic generator/checker on the MIG user (app_*) interface, in the ui_clk domain.
//  Per start pulse: writes NUM_WORDS words from START_ADDR, reads them back in order, compares each against the regenerated pattern.
//  Reports pass/fail, error count, first failing address and a watchdog timeout. Drives board LEDs at top level.
// PARAMETERS
//  ADDR_WIDTH      28      app_addr width (rank+bank+row+col)
//  APP_DATA_WIDTH  128     app_wdf_data/app_rd_data width (2*nCK_PER_CLK*DQ); must be a multiple of 32
//  START_ADDR      0       first app_addr of the sweep
//  NUM_WORDS       256     words per pass, >=1; index width IW=$clog2(NUM_WORDS+1)
//  ADDR_STEP       8       app_addr increment per word (8 columns for BL8)
//  PATTERN_SEED    32'hCAFEFACE  XOR seed for data pattern
//  ERR_CNT_WIDTH   16      width of err_count
//  TIMEOUT_CYCLES  65535   max ui_clk cycles with no handshake before timeout
// PORTS
//  ui_clk               in   1     clock (MIG user clock)
//  ui_clk_sync_rst      in   1     reset, synchronous, active-high
//  init_calib_complete  in   1     MIG calibration done
//  start                in   1     one-cycle pulse: begin a pass
//  app_addr             out  ADDR_WIDTH  command address
//  app_cmd              out  3     3'b000 write, 3'b001 read
//  app_en               out  1     command valid
//  app_rdy              in   1     command accepted when app_en&app_rdy
//  app_wdf_data         out  APP_DATA_WIDTH  write data
//  app_wdf_wren         out  1     write data valid
//  app_wdf_end          out  1     = app_wdf_wren (single beat per word)
//  app_wdf_mask         out  APP_DATA_WIDTH/8  constant 0
//  app_wdf_rdy          in   1     data accepted when app_wdf_wren&app_wdf_rdy
//  app_rd_data          in   APP_DATA_WIDTH  read data
//  app_rd_data_valid    in   1     read data beat valid
//  busy                 out  1     pass in progress
//  done                 out  1     one-cycle pulse at end of pass
//  pass / fail          out  1     sticky result, cleared on accepted start
//  timeout              out  1     sticky watchdog flag, cleared on accepted start
//  err_count            out  ERR_CNT_WIDTH  mismatching words, saturating
//  first_err_addr       out  ADDR_WIDTH  app_addr of first mismatch (0 if none)
// BEHAVIOUR
//  - Reset: state IDLE; app_en, app_wdf_wren, busy, done, pass, fail, timeout = 0; err_count, first_err_addr, app_addr, app_cmd = 0.
//  - Pattern: word i, 32-bit lane k = {i[23:0], k[7:0]} ^ PATTERN_SEED. Address i = (START_ADDR + i*ADDR_STEP) mod 2^ADDR_WIDTH (wraps silently).
//  - FSM IDLE -> WAIT_CAL -> WRITE -> READ -> DONE -> IDLE. start accepted only in IDLE; ignored while busy.
//  - WAIT_CAL: hold until init_calib_complete=1 (1 cycle min).
//  - WRITE: independent cmd counter and data counter; app_en/app_wdf_wren held with stable addr/data until own handshake, next word presented the following cycle (throughput 1 word/cycle if rdy). Leave when both counters = NUM_WORDS and both valids low.
//  - READ: issue NUM_WORDS read cmds (same handshake); concurrently compare each app_rd_data_valid beat, in order, against pattern(rd_idx). Mismatch: err_count+1 (saturate at all-ones); first mismatch latches its address. Beats beyond NUM_WORDS ignored.
//  - Leave READ when rd_idx = NUM_WORDS. DONE: 1 cycle, done=1, busy=0, pass=(err_count==0 && !timeout), fail=!pass.
//  - Watchdog: counter cleared on any handshake or rd beat; in WRITE/READ reaching TIMEOUT_CYCLES -> timeout=1, drop app_en/app_wdf_wren, go DONE (fail=1).
//  - busy=1 from cycle after accepted start through READ. Reset mid-pass: immediate return to reset values, no further commands.
// CONFIGURATION
//  MIG_CHK_ERR_INJECT_EN defined: extra input err_inject (1 bit) sampled with start; if 1, write data of word 0 has bit 0 inverted -> that pass reports exactly one error at START_ADDR.
//  Not defined: port absent, write data always equals pattern.
// TESTING
//  1. Ideal MIG model, app_rdy=app_wdf_rdy=1, NUM_WORDS=4, start -> 4 writes addr 0,8,16,24, 4 reads, done, pass=1, err_count=0.
//  2. Model corrupts bit 5 of word 2 on read -> fail=1, err_count=1, first_err_addr=16.
//  3. Random app_rdy/app_wdf_rdy backpressure, data accepted before cmd -> every word written exactly once, pass=1.
//  4. init_calib_complete low for 100 cycles after start -> no app_en until calib, then pass=1.
//  5. Model never returns read data, TIMEOUT_CYCLES=50 -> timeout=1, fail=1, done within 51 cycles of last handshake.
//  6. MIG_CHK_ERR_INJECT_EN with err_inject=1 -> err_count=1, first_err_addr=START_ADDR; reset asserted mid-READ -> all outputs to reset values next cycle.

Source files
------------

// File: rtl/mig_traffic_checker.sv
// DDR3 write/read-back traffic checker on the MIG app_* interface, ui_clk domain.
// Build option MIG_CHK_ERR_INJECT_EN adds err_inject to corrupt bit 0 of word 0 on write.
module mig_traffic_checker #(
  parameter int          ADDR_WIDTH     = 28,
  parameter int          APP_DATA_WIDTH = 128,
  parameter int          START_ADDR     = 0,
  parameter int          NUM_WORDS      = 256,
  parameter int          ADDR_STEP      = 8,
  parameter logic [31:0] PATTERN_SEED   = 32'hCAFEFACE,
  parameter int          ERR_CNT_WIDTH  = 16,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic                          ui_clk,
  input  logic                          ui_clk_sync_rst,
  input  logic                          init_calib_complete,
  input  logic                          start,
`ifdef MIG_CHK_ERR_INJECT_EN
  input  logic                          err_inject,
`endif
  output logic [ADDR_WIDTH-1:0]         app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [APP_DATA_WIDTH-1:0]     app_wdf_data,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [APP_DATA_WIDTH/8-1:0]   app_wdf_mask,
  input  logic                          app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]     app_rd_data,
  input  logic                          app_rd_data_valid,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [ERR_CNT_WIDTH-1:0]      err_count,
  output logic [ADDR_WIDTH-1:0]         first_err_addr,
  output logic [2:0]                    dbg_state
);
  localparam int IW    = $clog2(NUM_WORDS + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LANES = APP_DATA_WIDTH / 32;
  localparam logic [IW-1:0]         LP_N       = IW'(NUM_WORDS);
  localparam logic [IW-1:0]         LP_ONE     = IW'(1);
  localparam logic [TW-1:0]         LP_TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] LP_START   = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_STEP    = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [2:0]            CMD_WR     = 3'b000;
  localparam logic [2:0]            CMD_RD     = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DONE} state_t;

  state_t                      r_state, w_next;
  logic                        r_app_en, r_wren, r_pass, r_fail, r_timeout;
  logic [2:0]                  r_app_cmd;
  logic [ADDR_WIDTH-1:0]       r_app_addr, r_rd_addr, r_first_err_addr;
  logic [APP_DATA_WIDTH-1:0]   r_wdata;
  logic [IW-1:0]               r_cmd_idx, r_wd_idx, r_rd_idx;
  logic [TW-1:0]               r_wd_cnt;
  logic [ERR_CNT_WIDTH-1:0]    r_err_count;
  logic                        w_inject_bit;

  function automatic logic [APP_DATA_WIDTH-1:0] f_pattern(input logic [IW-1:0] idx);
    logic [APP_DATA_WIDTH-1:0] v;
    v = '0;
    for (int k = 0; k < LANES; k++) v[k*32 +: 32] = {24'(idx), 8'(k)} ^ PATTERN_SEED;
    return v;
  endfunction

`ifdef MIG_CHK_ERR_INJECT_EN
  logic r_inject;
  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) r_inject <= 1'b0;
    else if (r_state == S_IDLE && start) r_inject <= err_inject;
  end
  assign w_inject_bit = r_inject;
`else
  assign w_inject_bit = 1'b0;
`endif

  logic            w_cmd_hs, w_wd_hs, w_rd_beat, w_activity, w_in_xfer, w_wd_hit;
  logic            w_write_done, w_mismatch, w_enter_done, w_pass_now;
  logic [IW-1:0]   w_cmd_idx_nxt, w_wd_idx_nxt;

  assign w_cmd_hs      = r_app_en & app_rdy;
  assign w_wd_hs       = r_wren & app_wdf_rdy;
  assign w_rd_beat     = app_rd_data_valid && (r_state == S_READ) && (r_rd_idx != LP_N);
  assign w_activity    = w_cmd_hs | w_wd_hs | app_rd_data_valid;
  assign w_in_xfer     = (r_state == S_WRITE) || (r_state == S_READ);
  assign w_wd_hit      = w_in_xfer && !w_activity && (r_wd_cnt >= LP_TO_LAST);
  assign w_write_done  = (r_cmd_idx == LP_N) && (r_wd_idx == LP_N) && !r_app_en && !r_wren;
  assign w_mismatch    = w_rd_beat && (app_rd_data != f_pattern(r_rd_idx));
  assign w_cmd_idx_nxt = r_cmd_idx + LP_ONE;
  assign w_wd_idx_nxt  = r_wd_idx + LP_ONE;
  assign w_enter_done  = (w_next == S_DONE) && (r_state != S_DONE);
  assign w_pass_now    = (r_err_count == '0) && !r_timeout && !w_wd_hit;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) r_state <= S_IDLE;
    else                 r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_WAIT_CAL;
      S_WAIT_CAL: if (init_calib_complete) w_next = S_WRITE;
      S_WRITE:    if (w_wd_hit) w_next = S_DONE;
                  else if (w_write_done) w_next = S_READ;
      S_READ:     if (w_wd_hit || r_rd_idx == LP_N) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_app_en <= 1'b0;  r_app_cmd <= 3'b000;  r_app_addr <= '0;
      r_wren <= 1'b0;    r_wdata <= '0;
      r_cmd_idx <= '0;   r_wd_idx <= '0;       r_rd_idx <= '0;   r_rd_addr <= '0;
      r_wd_cnt <= '0;    r_pass <= 1'b0;       r_fail <= 1'b0;   r_timeout <= 1'b0;
      r_err_count <= '0; r_first_err_addr <= '0;
    end else begin
      // Idle-cycle counter: any handshake or read beat restarts it.
      if (w_in_xfer && !w_activity) r_wd_cnt <= r_wd_cnt + TW'(1);
      else                          r_wd_cnt <= '0;
      case (r_state)
        S_IDLE: if (start) begin
          r_pass <= 1'b0; r_fail <= 1'b0; r_timeout <= 1'b0;
          r_err_count <= '0; r_first_err_addr <= '0;
        end
        S_WAIT_CAL: if (init_calib_complete) begin
          r_app_en <= 1'b1; r_app_cmd <= CMD_WR; r_app_addr <= LP_START;
          r_wren <= 1'b1;
          r_wdata <= f_pattern('0) ^ {{(APP_DATA_WIDTH-1){1'b0}}, w_inject_bit};
          r_cmd_idx <= '0; r_wd_idx <= '0;
        end
        S_WRITE: begin
          if (w_wd_hit) begin
            r_app_en <= 1'b0; r_wren <= 1'b0; r_timeout <= 1'b1;
          end else if (w_write_done) begin
            r_app_en <= 1'b1; r_app_cmd <= CMD_RD; r_app_addr <= LP_START;
            r_cmd_idx <= '0; r_rd_idx <= '0; r_rd_addr <= LP_START;
          end else begin
            if (w_cmd_hs) begin
              r_cmd_idx <= w_cmd_idx_nxt; r_app_addr <= r_app_addr + LP_STEP;
              if (w_cmd_idx_nxt == LP_N) r_app_en <= 1'b0;
            end
            if (w_wd_hs) begin
              r_wd_idx <= w_wd_idx_nxt; r_wdata <= f_pattern(w_wd_idx_nxt);
              if (w_wd_idx_nxt == LP_N) r_wren <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (w_wd_hit) begin
            r_app_en <= 1'b0; r_timeout <= 1'b1;
          end else begin
            if (w_cmd_hs) begin
              r_cmd_idx <= w_cmd_idx_nxt; r_app_addr <= r_app_addr + LP_STEP;
              if (w_cmd_idx_nxt == LP_N) r_app_en <= 1'b0;
            end
            if (w_rd_beat) begin
              r_rd_idx <= r_rd_idx + LP_ONE; r_rd_addr <= r_rd_addr + LP_STEP;
            end
            if (w_mismatch) begin
              if (r_err_count == '0) r_first_err_addr <= r_rd_addr;
              if (r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
            end
            if (r_rd_idx == LP_N) r_app_en <= 1'b0;
          end
        end
        default: ;
      endcase
      if (w_enter_done) begin
        r_pass <= w_pass_now; r_fail <= !w_pass_now;
      end
    end
  end

  assign app_addr       = r_app_addr;
  assign app_cmd        = r_app_cmd;
  assign app_en         = r_app_en;
  assign app_wdf_data   = r_wdata;
  assign app_wdf_wren   = r_wren;
  assign app_wdf_end    = r_wren;
  assign app_wdf_mask   = '0;
  assign busy           = (r_state == S_WAIT_CAL) || w_in_xfer;
  assign done           = (r_state == S_DONE);
  assign pass           = r_pass;
  assign fail           = r_fail;
  assign timeout        = r_timeout;
  assign err_count      = r_err_count;
  assign first_err_addr = r_first_err_addr;
  assign dbg_state      = r_state;
endmodule
